// File: rtl/common_pkg.sv
// Shared constants and types for the UART writeback reporter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Optional build macro: UART_REPORTER_CHECKSUM_EN adds a 7th XOR checksum byte.
package common_pkg;

    localparam logic [7:0] UART_SYNC_BYTE = 8'hA5;

`ifdef UART_REPORTER_CHECKSUM_EN
    localparam int REPORT_PKT_BYTES = 7;
`else
    localparam int REPORT_PKT_BYTES = 6;
`endif

    typedef struct packed {
        logic [4:0]  id;
        logic [31:0] data;
    } report_entry_t;

    typedef enum logic [1:0] {
        PK_IDLE  = 2'd0,
        PK_SEND  = 2'd1,
        PK_DRAIN = 2'd2
    } pk_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer, LSB first, CLKS_PER_BIT clocks per bit.
// Latency: byte accepted at edge A, start bit appears on tx_serial from edge A+1.
// Backpressure: byte_ready is high only while idle; a byte is taken on byte_valid && byte_ready.
//
// Ports: clk, rst (async active-low), byte_data/byte_valid/byte_ready (byte handshake),
//        tx_serial (registered UART line, idles high).
module uart_tx_byte
    import common_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       tx_serial
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    tx_state_t        state, state_nxt;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             bit_done;
    logic             line_nxt;

    assign bit_done = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= TX_IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            TX_IDLE:  if (byte_valid)                   state_nxt = TX_START;
            TX_START: if (bit_done)                     state_nxt = TX_DATA;
            TX_DATA:  if (bit_done && bit_idx == 3'd7)  state_nxt = TX_STOP;
            TX_STOP:  if (bit_done)                     state_nxt = TX_IDLE;
            default:                                    state_nxt = TX_IDLE;
        endcase
    end

    // Baud counter, bit index and shift register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else if (state == TX_IDLE) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            if (byte_valid) shreg <= byte_data;
        end else if (bit_done) begin
            baud_cnt <= '0;
            if (state == TX_DATA) begin
                bit_idx <= bit_idx + 3'd1;
                shreg   <= {1'b0, shreg[7:1]};
            end
        end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
        end
    end

    // Outputs
    always_comb begin
        byte_ready = (state == TX_IDLE);
        case (state)
            TX_START: line_nxt = 1'b0;
            TX_DATA:  line_nxt = shreg[0];
            default:  line_nxt = 1'b1;
        endcase
    end

    // Registered line keeps tx_serial glitch-free; reset forces it high at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tx_serial <= 1'b1;
        else      tx_serial <= line_nxt;
    end

endmodule

// File: rtl/uart_reporter.sv
// Buffers register writeback events and sends each as a framed UART packet.
// Latency: push at edge N, pop at N+1, byte accepted at N+2, start bit from N+3.
// Backpressure: none toward the pipeline; events arriving at a full FIFO are dropped and flagged.
//
// Ports: clk, rst (async active-low), event_valid/event_id/event_data (writeback capture),
//        tx_serial (UART line), busy (work pending), overflow (sticky drop flag).
// Build macro: UART_REPORTER_CHECKSUM_EN appends an XOR checksum byte over id and data bytes.
module uart_reporter
    import common_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        event_valid,
    input  logic [4:0]  event_id,
    input  logic [31:0] event_data,
    output logic        tx_serial,
    output logic        busy,
    output logic        overflow
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    report_entry_t fifo_mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          fifo_empty, fifo_full;
    logic          push, pop;

    pk_state_t     pk_state, pk_state_nxt;
    report_entry_t hold;
    logic [2:0]    byte_idx;
    logic          last_byte;
    logic [7:0]    byte_data;
    logic          byte_valid, byte_ready;

    // Extra pointer bit distinguishes full from empty.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = (pk_state == PK_IDLE) && !fifo_empty;
    // A simultaneous pop frees the slot being written, so a full FIFO still accepts.
    assign push       = event_valid && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= '{id: event_id, data: event_data};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (event_valid && !push) overflow <= 1'b1;
        end
    end

    // Holding register and byte index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold     <= '0;
            byte_idx <= '0;
        end else if (pop) begin
            hold     <= fifo_mem[rd_ptr[AW-1:0]];
            byte_idx <= '0;
        end else if (byte_valid && byte_ready) begin
            byte_idx <= byte_idx + 3'd1;
        end
    end

    assign last_byte = (byte_idx == 3'(REPORT_PKT_BYTES - 1));

    // Packetizer state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pk_state <= PK_IDLE;
        else      pk_state <= pk_state_nxt;
    end

    // Packetizer next state
    always_comb begin
        pk_state_nxt = pk_state;
        case (pk_state)
            PK_IDLE:  if (!fifo_empty)                           pk_state_nxt = PK_SEND;
            PK_SEND:  if (byte_valid && byte_ready && last_byte) pk_state_nxt = PK_DRAIN;
            PK_DRAIN: if (byte_ready)                            pk_state_nxt = PK_IDLE;
            default:                                             pk_state_nxt = PK_IDLE;
        endcase
    end

`ifdef UART_REPORTER_CHECKSUM_EN
    logic [7:0] checksum;
    assign checksum = {3'b000, hold.id} ^ hold.data[7:0] ^ hold.data[15:8]
                    ^ hold.data[23:16] ^ hold.data[31:24];
`endif

    // Packetizer outputs: byte selection
    always_comb begin
        byte_valid = (pk_state == PK_SEND);
        byte_data  = UART_SYNC_BYTE;
        case (byte_idx)
            3'd1:    byte_data = {3'b000, hold.id};
            3'd2:    byte_data = hold.data[7:0];
            3'd3:    byte_data = hold.data[15:8];
            3'd4:    byte_data = hold.data[23:16];
            3'd5:    byte_data = hold.data[31:24];
`ifdef UART_REPORTER_CHECKSUM_EN
            3'd6:    byte_data = checksum;
`endif
            default: byte_data = UART_SYNC_BYTE;
        endcase
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk       (clk),
        .rst       (rst),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .tx_serial (tx_serial)
    );

    // Serializer idle is exactly byte_ready.
    assign busy = !fifo_empty || (pk_state != PK_IDLE) || !byte_ready;

endmodule

// File: tb/tb_uart_reporter.sv
`timescale 1ns/1ps
module tb_uart_reporter;
    import common_pkg::*;

    localparam int CPB = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        event_valid = 1'b0;
    logic [4:0]  event_id = '0;
    logic [31:0] event_data = '0;
    logic        tx_serial, busy, overflow;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_reporter #(
        .CLK_FREQ  (8),
        .BAUD_RATE (1),
        .FIFO_DEPTH(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .event_valid(event_valid),
        .event_id   (event_id),
        .event_data (event_data),
        .tx_serial  (tx_serial),
        .busy       (busy),
        .overflow   (overflow)
    );

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // UART receiver: samples mid-bit on falling clock edges; a frame that sees reset is discarded.
    initial begin : rx_model
        logic [7:0] b;
        logic       ok;
        forever begin
            @(negedge clk);
            if (rst && tx_serial === 1'b0) begin
                ok = 1'b1;
                repeat (CPB / 2) @(negedge clk);
                if (tx_serial !== 1'b0 || !rst) ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx_serial;
                    if (!rst) ok = 1'b0;
                end
                repeat (CPB) @(negedge clk);
                if (tx_serial !== 1'b1 || !rst) ok = 1'b0;
                if (ok) rx_q.push_back(b);
            end
        end
    end

    task automatic send_event(input logic [4:0] id, input logic [31:0] d);
        event_valid = 1'b1;
        event_id    = id;
        event_data  = d;
        @(negedge clk);
        event_valid = 1'b0;
    endtask

    task automatic expect_pkt(input logic [4:0] id, input logic [31:0] d);
        logic [7:0] idb;
        idb = {3'b000, id};
        exp_q.push_back(8'hA5);
        exp_q.push_back(idb);
        exp_q.push_back(d[7:0]);
        exp_q.push_back(d[15:8]);
        exp_q.push_back(d[23:16]);
        exp_q.push_back(d[31:24]);
`ifdef UART_REPORTER_CHECKSUM_EN
        exp_q.push_back(idb ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24]);
`endif
    endtask

    task automatic wait_rx(input int n, input int budget, input string tag);
        int c;
        c = 0;
        while (rx_q.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        check_vec({tag, "_rx_timeout"}, (rx_q.size() >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic compare_rx(input string tag);
        check_vec({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check_vec($sformatf("%s_byte%0d", tag, i),
                      (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hFFFF_FFFF,
                      {24'h0, exp_q[i]});
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vec_cnt);
        $fatal(1);
    end

    initial begin : main
        logic t_and, b_or, o_or, pre;
        int   c;

        // Reset
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        check_vec("rst_tx", tx_serial, 1);
        check_vec("rst_busy", busy, 0);
        check_vec("rst_ovf", overflow, 0);
        rst = 1'b1;
        t_and = 1'b1; b_or = 1'b0; o_or = 1'b0;
        repeat (200) begin
            @(negedge clk);
            t_and &= tx_serial; b_or |= busy; o_or |= overflow;
        end
        check_vec("idle_tx", t_and, 1);
        check_vec("idle_busy", b_or, 0);
        check_vec("idle_ovf", o_or, 0);

        // Single event and first start-bit timing
        expect_pkt(5'd5, 32'hDEADBEEF);
        send_event(5'd5, 32'hDEADBEEF);          // pushed at edge N, now after N
        check_vec("single_busy", busy, 1);
        pre = tx_serial;
        @(negedge clk); pre &= tx_serial;        // after N+1
        @(negedge clk); pre &= tx_serial;        // after N+2
        check_vec("start_pre_high", pre, 1);
        @(negedge clk);                          // after N+3
        check_vec("start_bit_n3", tx_serial, 0);
        wait_rx(6, 800, "single");
        check_vec("busy_in_last_stop", busy, 1);
        c = 0;
        while (busy && c < 20) begin @(negedge clk); c++; end
        check_vec("busy_fall", busy, 0);
        repeat (20) @(negedge clk);
        compare_rx("single");

        // Three consecutive-cycle events
        for (int i = 1; i <= 3; i++) expect_pkt(5'(i), 32'(i));
        for (int i = 1; i <= 3; i++) send_event(5'(i), 32'(i));
        wait_rx(18, 1800, "burst3");
        repeat (30) @(negedge clk);
        check_vec("burst3_ovf", overflow, 0);
        compare_rx("burst3");

        // Ten back-to-back events into a 4-deep FIFO: 1 in flight + 4 buffered survive
        for (int i = 0; i < 5; i++) expect_pkt(5'(10 + i), 32'h1111_0000 + 32'(i));
        for (int i = 0; i < 10; i++) send_event(5'(10 + i), 32'h1111_0000 + 32'(i));
        check_vec("ovf_set", overflow, 1);
        wait_rx(30, 3000, "ovf");
        repeat (300) @(negedge clk);
        check_vec("ovf_sticky", overflow, 1);
        check_vec("ovf_drained_busy", busy, 0);
        compare_rx("ovf");

        // Reset in the middle of a data byte of the second packet
        expect_pkt(5'd20, 32'hCAFE_0014);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h15);
        send_event(5'd20, 32'hCAFE_0014);
        send_event(5'd21, 32'hCAFE_0015);
        send_event(5'd22, 32'hCAFE_0016);
        wait_rx(8, 1300, "midrst");
        repeat (30) @(negedge clk);
        check_vec("midrst_busy_before", busy, 1);
        #2 rst = 1'b0;
        #1;
        check_vec("midrst_async_tx", tx_serial, 1);
        check_vec("midrst_async_ovf", overflow, 0);
        check_vec("midrst_async_busy", busy, 0);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        t_and = 1'b1; b_or = 1'b0;
        repeat (300) begin
            @(negedge clk);
            t_and &= tx_serial; b_or |= busy;
        end
        check_vec("midrst_line_quiet", t_and, 1);
        check_vec("midrst_fifo_empty", b_or, 0);
        compare_rx("midrst");

        // Post-reset packet (checksum byte 0x07 when the checksum build is used)
        expect_pkt(5'd3, 32'h01020304);
        send_event(5'd3, 32'h01020304);
        wait_rx(REPORT_PKT_BYTES, 900, "cksum");
        repeat (20) @(negedge clk);
        compare_rx("cksum");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
